// File: rtl/csr_demux_ordered.sv
// CSR router: fans one core CSR channel out to NumPorts accelerator windows and
// returns read responses in request order using an in-order ID FIFO.
module csr_demux_ordered #(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned RegsPerPort    = 8,
  parameter int unsigned AddrWidth      = 8,
  parameter int unsigned RegDataWidth   = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned PortAddrWidth  = $clog2(RegsPerPort),
  parameter int unsigned IdWidth        = $clog2(NumPorts + 1)
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [AddrWidth-1:0]                        csr_addr_i,
  input  logic [RegDataWidth-1:0]                     csr_wr_data_i,
  input  logic                                        csr_wr_en_i,
  input  logic                                        csr_req_valid_i,
  output logic                                        csr_req_ready_o,
  output logic [RegDataWidth-1:0]                     csr_rd_data_o,
  output logic                                        csr_rsp_valid_o,
  input  logic                                        csr_rsp_ready_i,
  output logic [NumPorts-1:0][PortAddrWidth-1:0]      acc_csr_addr_o,
  output logic [NumPorts-1:0][RegDataWidth-1:0]       acc_csr_wr_data_o,
  output logic [NumPorts-1:0]                         acc_csr_wr_en_o,
  output logic [NumPorts-1:0]                         acc_csr_req_valid_o,
  input  logic [NumPorts-1:0]                         acc_csr_req_ready_i,
  input  logic [NumPorts-1:0][RegDataWidth-1:0]       acc_csr_rd_data_i,
  input  logic [NumPorts-1:0]                         acc_csr_rsp_valid_i,
  output logic [NumPorts-1:0]                         acc_csr_rsp_ready_o,
  output logic [$clog2(MaxOutstanding):0]             outstanding_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1;
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [AddrWidth:0]    AddrLimit = (AddrWidth + 1)'(NumPorts * RegsPerPort);
  localparam logic [PtrWidth-1:0]   PtrLast   = PtrWidth'(MaxOutstanding - 1);
  localparam logic [IdWidth-1:0]    SinkId    = IdWidth'(NumPorts);
  localparam logic [CntWidth-1:0]   CntFull   = CntWidth'(MaxOutstanding);

  logic [AddrWidth-1:0] sel_s;
  logic                 oor_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic [IdWidth-1:0]   push_id_s;
  logic [IdWidth-1:0]   head_s;

  logic [IdWidth-1:0]   fifo_r [MaxOutstanding];
  logic [PtrWidth-1:0]  wr_ptr_r;
  logic [PtrWidth-1:0]  rd_ptr_r;
  logic [CntWidth-1:0]  count_r;

  function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrLast) ? {PtrWidth{1'b0}} : ptr + PtrWidth'(1);
  endfunction

  assign sel_s     = csr_addr_i >> PortAddrWidth;
  assign oor_s     = ({1'b0, csr_addr_i} >= AddrLimit);
  assign full_s    = (count_r == CntFull);
  assign empty_s   = (count_r == {CntWidth{1'b0}});
  assign head_s    = fifo_r[rd_ptr_r];
  assign push_id_s = oor_s ? SinkId : IdWidth'(sel_s);
  // Only reads occupy an ID slot; writes never produce a response.
  assign push_s    = csr_req_valid_i & csr_req_ready_o & ~csr_wr_en_i;
  assign pop_s     = csr_rsp_valid_o & csr_rsp_ready_i;
  assign outstanding_o = count_r;

  // Request demux: route the core request to the selected window only.
  always_comb begin
    acc_csr_addr_o      = '0;
    acc_csr_wr_data_o   = '0;
    acc_csr_wr_en_o     = '0;
    acc_csr_req_valid_o = '0;
    csr_req_ready_o     = 1'b0;
    if (oor_s) begin
      csr_req_ready_o = csr_wr_en_i ? 1'b1 : ~full_s;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (sel_s == AddrWidth'(p)) begin
          acc_csr_addr_o[p]    = csr_addr_i[PortAddrWidth-1:0];
          acc_csr_wr_data_o[p] = csr_wr_data_i;
          acc_csr_wr_en_o[p]   = csr_wr_en_i;
          if (csr_wr_en_i) begin
            acc_csr_req_valid_o[p] = csr_req_valid_i;
            csr_req_ready_o        = acc_csr_req_ready_i[p];
          end else begin
            acc_csr_req_valid_o[p] = csr_req_valid_i & ~full_s;
            csr_req_ready_o        = acc_csr_req_ready_i[p] & ~full_s;
          end
        end else begin
          acc_csr_req_valid_o[p] = 1'b0;
        end
      end
    end
  end

  // Response mux: only the FIFO head may hand a response to the core.
  always_comb begin
    csr_rsp_valid_o     = 1'b0;
    csr_rd_data_o       = '0;
    acc_csr_rsp_ready_o = '0;
    if (empty_s) begin
      csr_rsp_valid_o = 1'b0;
    end else if (head_s == SinkId) begin
      csr_rsp_valid_o = 1'b1;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (head_s == IdWidth'(p)) begin
          csr_rsp_valid_o        = acc_csr_rsp_valid_i[p];
          csr_rd_data_o          = acc_csr_rd_data_i[p];
          acc_csr_rsp_ready_o[p] = csr_rsp_ready_i;
        end else begin
          acc_csr_rsp_ready_o[p] = 1'b0;
        end
      end
    end
  end

  // ID FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= push_id_s;
        wr_ptr_r         <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntWidth'(1);
        2'b01:   count_r <= count_r - CntWidth'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
